regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Controls the single register-file write port. Single-cycle
//               ALU results have priority. Long-latency LSU/MUL results wait
//               in a small FIFO. A younger ALU write to the same register
//               squashes a queued entry (WAW). A starvation counter forces a
//               one-cycle ALU stall so that the FIFO head can drain.
//               Optional macro WB_BYPASS_EN adds two read ports that forward
//               the registered write data.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        write_ena,
  output logic [4:0]  write_reg_addr,
  output logic [31:0] data_in,
  output logic [31:0] pending_mask
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]  rd1_addr,
  input  logic [4:0]  rd2_addr,
  input  logic [31:0] rf_rd1_data,
  input  logic [31:0] rf_rd2_data,
  output logic [31:0] rd1_data,
  output logic [31:0] rd2_data
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] C_FULL        = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] C_STARVE_LAST = STV_W'(STARVE_MAX - 1);

  // FIFO storage and control
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PTR_W-1:0] rptr_q, wptr_q;
  logic [CNT_W-1:0] count_q;

  // Starvation control
  logic [STV_W-1:0] starve_q, starve_d;
  logic             stall_q, stall_d;

  // Registered write port
  logic        write_ena_q, write_ena_d;
  logic [4:0]  write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;

  logic alu_win, not_empty, head_live, drain, pop, push, push_killed;

  assign lsu_ready      = (count_q != C_FULL);
  assign alu_stall      = stall_q;
  assign write_ena      = write_ena_q;
  assign write_reg_addr = write_addr_q;
  assign data_in        = write_data_q;

  // alu_rd==0 is a non-write, which leaves the cycle free for the FIFO head
  assign alu_win     = alu_valid && !stall_q && (alu_rd != 5'd0);
  assign not_empty   = (count_q != '0);
  assign head_live   = not_empty && live_q[rptr_q];
  assign drain       = head_live && !alu_win;
  // A killed head leaves the FIFO even when the ALU owns the port
  assign pop         = not_empty && (drain || !live_q[rptr_q]);
  // rd0 results are acknowledged but never stored
  assign push        = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  assign push_killed = alu_win && (lsu_rd == alu_rd);

  // Choose what the write port carries next cycle
  always_comb begin
    write_ena_d  = 1'b0;
    write_addr_d = 5'd0;
    write_data_d = 32'd0;
    if (alu_win) begin
      write_ena_d  = 1'b1;
      write_addr_d = alu_rd;
      write_data_d = alu_data;
    end else if (drain) begin
      write_ena_d  = 1'b1;
      write_addr_d = rd_q[rptr_q];
      write_data_d = data_q[rptr_q];
    end
  end

  // Count cycles a live head waits; request a one-cycle ALU stall on expiry
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (!not_empty || drain) begin
      starve_d = '0;
    end else if (head_live) begin
      if (starve_q == C_STARVE_LAST) begin
        stall_d  = 1'b1;
        starve_d = '0;
      end else begin
        starve_d = starve_q + STV_W'(1);
      end
    end
  end

  // Decode live entries into the hazard mask
  always_comb begin
    pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_mask[rd_q[i]] = 1'b1;
    end
  end

  // Write-port, stall and starvation registers
  always_ff @(posedge clk) begin
    if (rst) begin
      write_ena_q  <= 1'b0;
      write_addr_q <= 5'd0;
      write_data_q <= 32'd0;
      stall_q      <= 1'b0;
      starve_q     <= '0;
    end else begin
      write_ena_q  <= write_ena_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      stall_q      <= stall_d;
      starve_q     <= starve_d;
    end
  end

  // FIFO control: WAW squash, pop and push (later assignments take precedence)
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_win && (rd_q[i] == alu_rd)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rptr_q] <= 1'b0;
        rptr_q         <= rptr_q + PTR_W'(1);
      end
      if (push) begin
        live_q[wptr_q] <= !push_killed;
        wptr_q         <= wptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO payload storage; validity is tracked by live_q alone
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr_q]   <= lsu_rd;
      data_q[wptr_q] <= lsu_data;
    end
  end

`ifdef WB_BYPASS_EN
  // Same-cycle write-through forwarding for the two read ports
  assign rd1_data = (write_ena_q && (write_addr_q == rd1_addr) && (rd1_addr != 5'd0))
                    ? write_data_q : rf_rd1_data;
  assign rd2_data = (write_ena_q && (write_addr_q == rd2_addr) && (rd2_addr != 5'd0))
                    ? write_data_q : rf_rd2_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed test of regfile_wb_arbiter with hand-computed
//               expectations (DEPTH=4, STARVE_MAX=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        write_ena;
  logic [4:0]  write_reg_addr;
  logic [31:0] data_in;
  logic [31:0] pending_mask;
`ifdef WB_BYPASS_EN
  logic [4:0]  rd1_addr = 5'd0, rd2_addr = 5'd0;
  logic [31:0] rf_rd1_data = 32'd0, rf_rd2_data = 32'd0;
  logic [31:0] rd1_data, rd2_data;
`endif

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_stall      (alu_stall),
    .lsu_valid      (lsu_valid),
    .lsu_ready      (lsu_ready),
    .lsu_rd         (lsu_rd),
    .lsu_data       (lsu_data),
    .write_ena      (write_ena),
    .write_reg_addr (write_reg_addr),
    .data_in        (data_in),
    .pending_mask   (pending_mask)
`ifdef WB_BYPASS_EN
    ,
    .rd1_addr       (rd1_addr),
    .rd2_addr       (rd2_addr),
    .rf_rd1_data    (rf_rd1_data),
    .rf_rd2_data    (rf_rd2_data),
    .rd1_data       (rd1_data),
    .rd2_data       (rd2_data)
`endif
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] addr,
                        input logic [31:0] data);
    chk({tag, ".ena"}, {31'd0, write_ena}, {31'd0, en});
    if (en) begin
      chk({tag, ".addr"}, {27'd0, write_reg_addr}, {27'd0, addr});
      chk({tag, ".data"}, data_in, data);
    end
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = v;
    lsu_rd    = rd;
    lsu_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    alu(1'b0, 5'd0, 32'd0);
    lsu(1'b0, 5'd0, 32'd0);
    #1;
    step();
    step();
    // Reset state
    chk_wr("rst", 1'b0, 5'd0, 32'd0);
    chk("rst.addr", {27'd0, write_reg_addr}, 32'd0);
    chk("rst.data", data_in, 32'd0);
    chk("rst.stall", {31'd0, alu_stall}, 32'd0);
    chk("rst.ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst.mask", pending_mask, 32'd0);
    rst = 1'b0;

    // ALU priority: one write, visible the cycle after selection only
    alu(1'b1, 5'd5, 32'h1234);
    step();
    chk_wr("alu.wr", 1'b1, 5'd5, 32'h1234);
    alu(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("alu.once", 1'b0, 5'd0, 32'd0);

    // FIFO drain with the ALU idle
    lsu(1'b1, 5'd3, 32'hAA);
    step();
    chk_wr("drain.t1", 1'b0, 5'd0, 32'd0);
    chk("drain.mask1", pending_mask, 32'h0000_0008);
    lsu(1'b1, 5'd4, 32'hBB);
    step();
    chk_wr("drain.r3", 1'b1, 5'd3, 32'hAA);
    chk("drain.mask2", pending_mask, 32'h0000_0010);
    lsu(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("drain.r4", 1'b1, 5'd4, 32'hBB);
    chk("drain.mask3", pending_mask, 32'd0);
    step();
    chk_wr("drain.idle", 1'b0, 5'd0, 32'd0);

    // Fill the FIFO while the ALU owns the port every cycle
    alu(1'b1, 5'd1, 32'h1);
    lsu(1'b1, 5'd10, 32'h100);
    step();
    lsu(1'b1, 5'd11, 32'h101);
    step();
    lsu(1'b1, 5'd12, 32'h102);
    step();
    chk("full.ready3", {31'd0, lsu_ready}, 32'd1);
    lsu(1'b1, 5'd13, 32'h103);
    step();
    chk("full.ready4", {31'd0, lsu_ready}, 32'd0);
    chk("full.mask", pending_mask, 32'h0000_3C00);
    chk_wr("full.alu", 1'b1, 5'd1, 32'h1);
    // Free one slot
    alu(1'b0, 5'd0, 32'd0);
    lsu(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("full.r10", 1'b1, 5'd10, 32'h100);
    chk("full.ready_after_pop", {31'd0, lsu_ready}, 32'd1);
    // rd0 push is accepted but must not occupy a slot
    alu(1'b1, 5'd1, 32'h2);
    lsu(1'b1, 5'd0, 32'hDEAD);
    chk("rd0.ready", {31'd0, lsu_ready}, 32'd1);
    step();
    chk("rd0.not_queued", {31'd0, lsu_ready}, 32'd1);
    chk("rd0.mask", pending_mask, 32'h0000_3800);
    chk_wr("rd0.alu", 1'b1, 5'd1, 32'h2);
    alu(1'b0, 5'd0, 32'd0);
    lsu(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("full.r11", 1'b1, 5'd11, 32'h101);
    step();
    chk_wr("full.r12", 1'b1, 5'd12, 32'h102);
    step();
    chk_wr("full.r13", 1'b1, 5'd13, 32'h103);
    chk("full.mask_empty", pending_mask, 32'd0);
    step();
    chk_wr("rd0.no_write", 1'b0, 5'd0, 32'd0);

    // WAW squash: queued entry killed by a later ALU write
    alu(1'b1, 5'd2, 32'h22);
    lsu(1'b1, 5'd7, 32'h77);
    step();
    chk("waw1.mask", pending_mask, 32'h0000_0080);
    alu(1'b1, 5'd7, 32'h55);
    lsu(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("waw1.alu", 1'b1, 5'd7, 32'h55);
    chk("waw1.mask_clr", pending_mask, 32'd0);
    alu(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("waw1.no_lsu", 1'b0, 5'd0, 32'd0);
    step();
    chk_wr("waw1.quiet", 1'b0, 5'd0, 32'd0);

    // WAW squash: push and ALU write to the same register in one cycle
    alu(1'b1, 5'd7, 32'h55);
    lsu(1'b1, 5'd7, 32'h99);
    step();
    chk_wr("waw2.alu", 1'b1, 5'd7, 32'h55);
    chk("waw2.mask", pending_mask, 32'd0);
    alu(1'b0, 5'd0, 32'd0);
    lsu(1'b0, 5'd0, 32'd0);
    step();
    chk_wr("waw2.no_lsu", 1'b0, 5'd0, 32'd0);
    step();
    chk_wr("waw2.quiet", 1'b0, 5'd0, 32'd0);
    chk("waw2.ready", {31'd0, lsu_ready}, 32'd1);

    // Starvation: one live entry behind continuous ALU writes
    alu(1'b1, 5'd1, 32'h11);
    lsu(1'b1, 5'd9, 32'h99);
    step();
    lsu(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 7; i++) step();
    chk("starve.no_stall_yet", {31'd0, alu_stall}, 32'd0);
    chk("starve.mask", pending_mask, 32'h0000_0200);
    step();
    chk("starve.stall", {31'd0, alu_stall}, 32'd1);
    chk_wr("starve.alu_last", 1'b1, 5'd1, 32'h11);
    step();
    chk("starve.stall_1cyc", {31'd0, alu_stall}, 32'd0);
    chk_wr("starve.head", 1'b1, 5'd9, 32'h99);
    chk("starve.mask_clr", pending_mask, 32'd0);
    step();
    chk_wr("starve.alu_resume", 1'b1, 5'd1, 32'h11);
    alu(1'b0, 5'd0, 32'd0);
    step();

    // Reset mid-operation with three queued entries
    alu(1'b1, 5'd1, 32'h33);
    lsu(1'b1, 5'd20, 32'h200);
    step();
    lsu(1'b1, 5'd21, 32'h201);
    step();
    lsu(1'b1, 5'd22, 32'h202);
    step();
    chk("rstmid.mask", pending_mask, 32'h0070_0000);
    alu(1'b0, 5'd0, 32'd0);
    lsu(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_wr("rstmid.ena", 1'b0, 5'd0, 32'd0);
    chk("rstmid.mask0", pending_mask, 32'd0);
    chk("rstmid.ready", {31'd0, lsu_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_wr("rstmid.no_write", 1'b0, 5'd0, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
